dram_sync: RTL
==============

Name: dram_sync

Overview:
Synchronous, parametrised single-port memory model that replaces the tristate-bus DRAM. It has separate read and write data buses, a req/ready handshake, a per-byte write mask, and a read pipeline of configurable latency. On every reset it runs a hardware init sweep that fills memory with INIT_BYTE. It sits between the CPU memory stage and the address decoder.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
DEPTH, 256, number of words.
ADDR_W, $clog2(DEPTH)+1, address width; the extra bit allows out-of-range detection.
RD_LATENCY, 2, cycles from read accept to rvalid; legal range 1..8.
INIT_BYTE, 8'hFF, byte value replicated into every word by the init sweep.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
req  in  1  request valid.
we  in  1  1 = write, 0 = read; sampled with req.
addr  in  ADDR_W  word address.
wdata  in  DATA_W  write data.
wmask  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
ready  out  1  request accepted when req && ready.
rdata  out  DATA_W  read data; valid only while rvalid=1.
rvalid  out  1  one-cycle pulse per accepted read.
rerr  out  1  qualifies rvalid; 1 = read address was out of range.
init_done  out  1  high once the init sweep has finished.

Behaviour:
- Reset (async assert): ready=0, rvalid=0, rerr=0, rdata=0, init_done=0, FSM=INIT, sweep counter=0, read pipeline flushed. Any read in flight is dropped and never returns.
- FSM INIT:
  - Each cycle writes {DATA_W/8{INIT_BYTE}} to word[cnt], then cnt++.
  - When cnt==DEPTH-1 has been written, the FSM moves to RUN. Total sweep = DEPTH cycles after rst deasserts.
  - ready=0 throughout; req is ignored.
- FSM RUN: ready=1 and init_done=1, registered, from the first RUN cycle. The FSM leaves RUN only on rst.
- Accept: one request per cycle when req && ready at the rising edge. Reads and writes are fully pipelined, so back-to-back requests of either kind run at full rate.
- Write:
  - At the accept edge, bytes with wmask[i]=1 are updated and the others keep their value.
  - wmask=0 is a legal no-op.
  - No response is returned.
- Read:
  - The memory word is sampled at the accept edge.
  - rvalid pulses exactly RD_LATENCY cycles later, with rdata and rerr, strictly in request order.
- Ordering: a read accepted in the cycle after a write to the same address returns the new data. Reads never see a later write.
- Out of range (addr >= DEPTH):
  - Write: dropped; memory unchanged.
  - Read: rdata = {INIT_BYTE...}, rerr=1, same latency.
- When rvalid=0, rdata holds its last value and rerr=0.
- Reset mid-operation: contents are re-initialised by a fresh sweep. The pipeline is cleared, so no stale rvalid appears after reset.
- Memory is a reg array [0:DEPTH-1]; there is no tristate anywhere.

Decomposition:
- Package dram_pkg holds:
  - the state typedef enum {ST_INIT, ST_RUN};
  - the default INIT_BYTE constant;
  - the RD_LATENCY_MAX=8 constant, used for elaboration-time range checks.
- Sub-module dram_rd_pipe: a parametrised RD_LATENCY-stage shift register carrying {valid, err, data}, with async clear on rst. The top holds the array, the FSM and the write/mask logic.

Test Plan:
- Init sweep: DEPTH=16, pulse rst. ready and init_done stay 0 for exactly 16 cycles after deassert. Then reading addr 0..15 returns 32'hFFFFFFFF each time, with rerr=0.
- Masked write then read: write addr 5, wdata 32'h11223344, wmask 4'b0101. A read of addr 5 returns 32'hFF22FF44 with rvalid exactly 2 cycles after accept.
- Back-to-back with forwarding: write addr 3 = 32'hA5A5A5A5 with full mask, immediately followed by reads of 3, 4, 3 on consecutive cycles. Three consecutive rvalid pulses carry A5A5A5A5, FFFFFFFF, A5A5A5A5.
- Latency parameter: RD_LATENCY=1 and RD_LATENCY=5, single read. rvalid rises exactly 1 and 5 cycles after accept respectively; no other rvalid pulse occurs.
- Out of range: DEPTH=16, write addr 20, then read addr 20 and addr 4. The read of 20 returns FFFFFFFF with rerr=1; the read of 4 returns FFFFFFFF with rerr=0.
- Reset mid-flight: issue a read, assert rst one cycle later. No rvalid appears, and the sweep restarts. A previously written word (addr 5) reads back FFFFFFFF after init_done.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and constants for the synchronous DRAM replacement model.
package dram_pkg;

    // Controller state: sweep memory with the init pattern, then serve requests.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Byte pattern written to every byte of memory by the init sweep.
    localparam logic [7:0] INIT_BYTE_DEFAULT = 8'hFF;

    // Deepest read pipeline the model supports.
    localparam int RD_LATENCY_MAX = 8;

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-response delay line: RD_LATENCY stages of {valid, err, data}.
// Data and err only advance alongside a valid token, so the last stage keeps
// showing the most recent response while no new one is in flight.
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [DATA_W-1:0]     data_q [RD_LATENCY];

    logic [RD_LATENCY-1:0] valid_d;
    logic [RD_LATENCY-1:0] err_d;
    logic [DATA_W-1:0]     data_d [RD_LATENCY];

    // Wire each stage's input to the previous stage (stage 0 takes the new read).
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = valid_i;
                assign err_d[gi]   = err_i;
                assign data_d[gi]  = data_i;
            end else begin : g_body
                assign valid_d[gi] = valid_q[gi-1];
                assign err_d[gi]   = err_q[gi-1];
                assign data_d[gi]  = data_q[gi-1];
            end
        end
    endgenerate

    // Shift tokens every cycle; payload moves only with a valid token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_d[i];
                if (valid_d[i]) begin
                    err_q[i]  <= err_d[i];
                    data_q[i] <= data_d[i];
                end
            end
        end
    end

    assign valid_o = valid_q[RD_LATENCY-1];
    assign err_o   = valid_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
    assign data_o  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/dram_sync.sv
// Synchronous single-port memory model with req/ready handshake, byte-masked
// writes, a fixed-latency read pipeline and a hardware init sweep after reset.
module dram_sync
    import dram_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter int         DEPTH      = 256,
    parameter int         ADDR_W     = $clog2(DEPTH) + 1,
    parameter int         RD_LATENCY = 2,
    parameter logic [7:0] INIT_BYTE  = INIT_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  rerr,
    output logic                  init_done
);

    localparam int NBYTES = DATA_W / 8;
    // The top address bit only exists to flag out-of-range accesses.
    localparam int IDX_W  = ADDR_W - 1;
    localparam logic [DATA_W-1:0] INIT_WORD = {NBYTES{INIT_BYTE}};

    // Reject parameter sets the datapath cannot represent.
    generate
        if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
            $error("dram_sync: RD_LATENCY must be in 1..%0d", RD_LATENCY_MAX);
        end
        if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
            $error("dram_sync: DATA_W must be a non-zero multiple of 8");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("dram_sync: DEPTH must be at least 2");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;
    logic              init_done_q;

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_word;
    logic [NBYTES-1:0] wr_be;

    assign accept   = req && ready_q;
    assign in_range = (addr < ADDR_W'(DEPTH));
    assign idx      = addr[IDX_W-1:0];

    // Single write port shared by the init sweep and accepted in-range writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_word = wdata;
        wr_be   = wmask;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_word = INIT_WORD;
            wr_be   = '1;
        end else if (accept && we && in_range) begin
            wr_en = 1'b1;
        end
    end

    // Byte-enabled memory write; unmasked bytes keep their old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Word sampled at the accept edge; out-of-range reads return the init pattern.
    assign rd_word = in_range ? mem_q[idx] : INIT_WORD;

    // Init sweep then run forever; ready/init_done are registered FSM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q     <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    dram_rd_pipe #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept && !we),
        .err_i   (!in_range),
        .data_i  (rd_word),
        .valid_o (rvalid),
        .err_o   (rerr),
        .data_o  (rdata)
    );

    assign ready     = ready_q;
    assign init_done = init_done_q;

endmodule
